// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master transmitter.
// Timing is expressed in system clocks: one SCK half-period is HALF_PERIOD clk cycles.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        DONE     = 2'd2
    } spi_state_e;

    localparam int NBITS       = 8;
    localparam int HALF_PERIOD = 2;
    localparam int NEDGES      = 2 * NBITS;
    localparam int DONE_CYCLES = 2;

    localparam int HALF_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int EDGE_W = $clog2(NEDGES);
    localparam int DONE_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: divides clk by 2*HALF_PERIOD while run is high and flags each
// leading/trailing SCK edge together with the final (16th) edge of a frame.
module spi_sck_gen
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic cpol,
    output logic sck,
    output logic leading,
    output logic trailing,
    output logic last_edge
);

    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              sck_q, sck_d;
    logic              tick;

    always_comb begin
        tick       = run && (half_cnt_q == HALF_W'(HALF_PERIOD - 1));
        half_cnt_d = half_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sck_d      = sck_q;
        if (clear) begin
            // Preload the idle level so the first toggle produces the leading edge.
            half_cnt_d = '0;
            edge_cnt_d = '0;
            sck_d      = cpol;
        end else if (run) begin
            if (tick) begin
                half_cnt_d = '0;
                edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                sck_d      = ~sck_q;
            end else begin
                half_cnt_d = half_cnt_q + HALF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            sck_q      <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sck_q      <= sck_d;
        end
    end

    // Even edge index (0-based) means odd k: the leading edge.
    assign sck       = sck_q;
    assign leading   = tick && !edge_cnt_q[0];
    assign trailing  = tick &&  edge_cnt_q[0];
    assign last_edge = tick && (edge_cnt_q == EDGE_W'(NEDGES - 1));

endmodule

// File: rtl/transmitter_spi.sv
// Single-byte full-duplex SPI master, MSB first, with run-time CPOL/CPHA selection.
// Mode and data are captured when a transfer starts and held for the whole frame.
module transmitter_spi
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             CPH,
    input  logic             CKP,
    input  logic             strt,
    input  logic             MISO,
    input  logic [NBITS-1:0] data_in,
    output logic             CS,
    output logic             MOSI,
    output logic             SCK
);

    spi_state_e        state_q, state_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic [NBITS-1:0]  tx_q, tx_d;
    logic [NBITS-1:0]  rx_data_q, rx_data_d;
    logic              cpha_q, cpha_d;
    logic              cpol_q, cpol_d;
    logic [DONE_W-1:0] done_cnt_q, done_cnt_d;

    logic sck_int;
    logic leading;
    logic trailing;
    logic last_edge;
    logic shift_edge;
    logic sample_edge;

    spi_sck_gen u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == IDLE),
        .run       (state_q == TRANSFER),
        .cpol      (CKP),
        .sck       (sck_int),
        .leading   (leading),
        .trailing  (trailing),
        .last_edge (last_edge)
    );

    assign shift_edge  = cpha_q ? leading  : trailing;
    assign sample_edge = cpha_q ? trailing : leading;

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        tx_d       = tx_q;
        rx_data_d  = rx_data_q;
        cpha_d     = cpha_q;
        cpol_d     = cpol_q;
        done_cnt_d = done_cnt_q;

        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                if (strt) begin
                    state_d    = TRANSFER;
                    cs_d       = 1'b0;
                    cpha_d     = CPH;
                    cpol_d     = CKP;
                    rx_data_d  = '0;
                    done_cnt_d = '0;
                    // CPHA=0 must have the MSB on the wire before the first SCK edge.
                    if (CPH) begin
                        tx_d   = data_in;
                        mosi_d = 1'b0;
                    end else begin
                        tx_d   = {data_in[NBITS-2:0], 1'b0};
                        mosi_d = data_in[NBITS-1];
                    end
                end
            end

            TRANSFER: begin
                if (shift_edge && !last_edge) begin
                    mosi_d = tx_q[NBITS-1];
                    tx_d   = {tx_q[NBITS-2:0], 1'b0};
                end
                if (sample_edge) begin
                    rx_data_d = {rx_data_q[NBITS-2:0], MISO};
                end
                if (last_edge) begin
                    state_d    = DONE;
                    done_cnt_d = '0;
                end
            end

            DONE: begin
                if (done_cnt_q == DONE_W'(DONE_CYCLES - 1)) begin
                    state_d = IDLE;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                end else begin
                    done_cnt_d = done_cnt_q + DONE_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            tx_q       <= '0;
            rx_data_q  <= '0;
            cpha_q     <= 1'b0;
            cpol_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            tx_q       <= tx_d;
            rx_data_q  <= rx_data_d;
            cpha_q     <= cpha_d;
            cpol_q     <= cpol_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // In IDLE the clock idles at the live polarity input; during a frame it is the divided clock.
    assign SCK  = (state_q == IDLE) ? CKP : sck_int;
    assign CS   = cs_q;
    assign MOSI = mosi_q;

endmodule

// File: tb/tb_transmitter_spi.sv
// Randomized bench for transmitter_spi: stimulus queues expected frames, a monitor
// watches CS/SCK/MOSI as a slave would and checks each frame against them.
module tb_transmitter_spi;

    logic       clk = 1'b0;
    logic       rst, cph, ckp, strt, miso, cs, mosi, sck;
    logic [7:0] data_in;
    logic       loop_en, miso_drv;

    assign miso = loop_en ? mosi : miso_drv;

    always #5 clk = ~clk;

    transmitter_spi dut (
        .clk     (clk),
        .rst     (rst),
        .CPH     (cph),
        .CKP     (ckp),
        .strt    (strt),
        .MISO    (miso),
        .data_in (data_in),
        .CS      (cs),
        .MOSI    (mosi),
        .SCK     (sck)
    );

    typedef struct {
        logic [7:0] data;
        logic       cph;
        logic       cpol;
        logic [7:0] slave;
        logic       loopback;
        int         gap;
    } frame_t;

    frame_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor / slave model
    frame_t cur;
    bit     in_frame = 1'b0;
    int     c, edges, sidx, timing_err, mosi_err;
    int     gap_cnt = 0;
    logic   prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    bit     ok;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (prev_cs === 1'b1 && cs === 1'b0) begin
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur        = exp_q.pop_front();
                    in_frame   = 1'b1;
                    c          = 0;
                    edges      = 0;
                    sidx       = 0;
                    timing_err = 0;
                    mosi_err   = 0;
                    if (cur.gap >= 0) check("cs_gap", gap_cnt, cur.gap);
                    check("mosi_at_t0", 32'(mosi), cur.cph ? 32'd0 : 32'(cur.data[7]));
                    if (sck !== cur.cpol) timing_err++;
                    miso_drv = cur.slave[7];
                end
            end else if (cs === 1'b1) begin
                gap_cnt++;
            end
        end else begin
            c++;
            if (cs === 1'b1 || c >= 40) begin
                check("cs_low_cycles", c, 34);
                check("sck_edges", edges, 16);
                check("mosi_samples", sidx, 8);
                check("sck_timing_errs", timing_err, 0);
                check("mosi_change_errs", mosi_err, 0);
                check("mosi_after_frame", 32'(mosi), 32'd0);
                check("rx_data", 32'(dut.rx_data_q), cur.loopback ? 32'(cur.data) : 32'(cur.slave));
                in_frame = 1'b0;
                gap_cnt  = 1;
            end else begin
                if (sck !== prev_sck) begin
                    edges++;
                    if (c != 2 * edges) timing_err++;
                    if (sck !== ((edges % 2 == 1) ? ~cur.cpol : cur.cpol)) timing_err++;
                    // CPHA=0 samples on odd (leading) edges, CPHA=1 on even (trailing) edges.
                    if ((cur.cph == 1'b0) == (edges % 2 == 1)) begin
                        if (sidx < 8) check($sformatf("mosi_bit%0d", 7 - sidx), 32'(mosi), 32'(cur.data[7 - sidx]));
                        sidx++;
                        if (sidx < 8) miso_drv = cur.slave[7 - sidx];
                    end
                end
                if (mosi !== prev_mosi) begin
                    if (cur.cph == 1'b0) ok = (c % 4 == 0) && (c >= 4) && (c <= 28);
                    else                 ok = (c % 4 == 2) && (c <= 30);
                    if (!ok) mosi_err++;
                end
                if (c == 33 && sck !== cur.cpol) timing_err++;
            end
        end
        prev_cs   = cs;
        prev_sck  = sck;
        prev_mosi = mosi;
    end

    // Called at a negedge; returns at the first negedge where the next frame may start.
    task automatic send(input logic [7:0] d, input logic p, input logic k, input logic [7:0] sl,
                        input logic lb, input int gap, input bit hold);
        frame_t f;
        strt    = 1'b1;
        data_in = d;
        cph     = p;
        ckp     = k;
        loop_en = lb;
        f = '{d, p, k, sl, lb, gap};
        exp_q.push_back(f);
        $display("[TB] frame data=0x%02h cph=%0d ckp=%0d slave=0x%02h loop=%0d", d, p, k, sl, lb);
        @(negedge clk);
        if (!hold) strt = 1'b0;
        repeat (34) begin
            data_in = 8'($urandom);
            cph     = 1'($urandom);
            ckp     = 1'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        int err;
        int extra;
        logic k;
        rst      = 1'b1;
        ckp      = 1'b1;
        cph      = 1'b0;
        strt     = 1'b0;
        data_in  = 8'h00;
        loop_en  = 1'b0;
        miso_drv = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_sck_ckp1", 32'(sck), 32'd1);
        check("rst_rx_data", 32'(dut.rx_data_q), 32'd0);
        ckp = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_sck_ckp0", 32'(sck), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);

        send(8'hA5, 1'b0, 1'b0, 8'($urandom), 1'b0, -1, 1'b0);
        @(negedge clk);
        ckp = 1'b1;
        #1 check("idle_sck_ckp1", 32'(sck), 32'd1);
        @(negedge clk);
        send(8'h3C, 1'b1, 1'b1, 8'h00, 1'b1, 3, 1'b0);
        @(negedge clk);
        send(8'h81, 1'b0, 1'b0, 8'($urandom), 1'b0, 2, 1'b1);
        send(8'h7E, 1'b0, 1'b0, 8'($urandom), 1'b0, 1, 1'b0);
        repeat (3) @(negedge clk);

        // Abort a frame with reset at t0+9
        mon_en   = 1'b0;
        k        = 1'($urandom);
        loop_en  = 1'b0;
        miso_drv = 1'b1;
        strt     = 1'b1;
        data_in  = 8'hFF;
        cph      = 1'($urandom);
        ckp      = k;
        $display("[TB] abort frame cph=%0d ckp=%0d", cph, k);
        @(negedge clk);
        strt = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_sck", 32'(sck), 32'(k));
        check("abort_rx_data", 32'(dut.rx_data_q), 32'd0);
        rst = 1'b0;
        err = 0;
        repeat (24) begin
            @(negedge clk);
            if (sck !== k || cs !== 1'b1) err++;
        end
        check("abort_quiet_errs", err, 0);
        mon_en = 1'b1;
        @(negedge clk);

        send(8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, -1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            extra = $urandom_range(0, 3);
            repeat (extra) @(negedge clk);
            send(8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1 + extra, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        check("monitor_idle", 32'(in_frame), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/transmitter_spi.md
TRANSMITTER_SPI -- requirements
Module: transmitter_spi

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 CPH  input  1  clock phase; 0 = sample on leading SCK edge, 1 = sample on trailing SCK edge.
REQ-005 CKP  input  1  clock polarity; idle level of SCK.
REQ-006 strt  input  1  start request; level-sampled in IDLE.
REQ-007 MISO  input  1  serial data from slave.
REQ-008 data_in  input  8  byte to transmit.
REQ-009 CS  output  1  active-low chip select.
REQ-010 MOSI  output  1  serial data to slave, MSB first.
REQ-011 SCK  output  1  serial clock.

Function
REQ-012 The block SHALL be an SPI master sending one 8-bit frame per transfer, MSB first, full duplex.
REQ-013 States SHALL be IDLE, TRANSFER and DONE.
REQ-014 In IDLE: CS=1, MOSI=0, SCK follows CKP combinationally from the live input.
REQ-015 IDLE->TRANSFER SHALL occur at the clk edge t0 where strt=1; at t0 data_in, CPH and CKP are latched, CS<=0, and the bit counter is cleared.
REQ-016 strt, data_in, CPH and CKP changes during TRANSFER/DONE SHALL be ignored.
REQ-017 SCK SHALL toggle every 2 clk cycles (SCK = clk/4), giving 16 SCK edges at t0+2k, k=1..16; odd k = leading edge (SCK becomes ~CKP), even k = trailing edge (SCK returns to CKP).
REQ-018 CPH=0: MOSI SHALL carry bit 7 from t0. It SHALL advance to the next lower bit on trailing edges k=2,4,...,14. MISO SHALL be sampled on leading edges.
REQ-019 CPH=1: MOSI SHALL present bit 7 at leading edge k=1. It SHALL advance to the next lower bit on each subsequent leading edge. MISO SHALL be sampled on trailing edges.
REQ-020 Sampled MISO bits SHALL shift MSB-first into an internal 8-bit receive register rx_data. That register SHALL be complete after the 8th sample and hold its value until the next transfer starts.
REQ-021 After edge 16 the FSM SHALL enter DONE, with SCK=CKP. At t0+34, CS<=1, MOSI<=0 and the FSM returns to IDLE.
REQ-022 The minimum CS-high gap between frames SHALL be 1 clk. If strt is still 1 in IDLE, a new transfer SHALL start on the next edge with fresh data_in.
REQ-023 MOSI SHALL change only on the SCK edge opposite to the sampling edge, or at t0 when CPH=0.

Reset
REQ-024 When rst=1 at a clk edge, the block SHALL enter IDLE with CS=1, MOSI=0, SCK=CKP, and the counters, shift registers and rx_data cleared.
REQ-025 Reset SHALL take priority over strt.
REQ-026 Reset mid-transfer SHALL abort the frame immediately; no partial completion.

Structure
REQ-027 A shared package spi_pkg SHALL hold the state enumeration (IDLE, TRANSFER, DONE), NBITS=8 and HALF_PERIOD=2.
REQ-028 SCK generation (half-period counter and edge strobes leading/trailing) SHALL be one sub-module, spi_sck_gen. The FSM and shift logic SHALL reside in transmitter_spi.

Verification
REQ-029 Reset hold with CKP=1 -> CS=1, MOSI=0, SCK=1. Then release with CKP=0 -> SCK=0.
REQ-030 Mode CKP=0, CPH=0, data_in=0xA5, one-cycle strt -> CS low for 34 clk. SCK shows 8 pulses, period 4 clk. MOSI at each rising edge = 1,0,1,0,0,1,0,1.
REQ-031 Mode CKP=1, CPH=1, data_in=0x3C, MISO tied to MOSI -> MOSI at each rising (trailing) edge = 0,0,1,1,1,1,0,0. rx_data=0x3C at end. SCK idles 1.
REQ-032 strt=1 held continuously with data_in 0x81 then 0x7E -> two back-to-back frames separated by a 1-clk CS-high gap. Second frame transmits 0x7E.
REQ-033 rst asserted at t0+9 during a frame -> next cycle CS=1, MOSI=0, SCK=CKP. No further SCK edges.
REQ-034 data_in and CPH changed mid-frame -> transmitted bits and timing are unchanged from the values latched at t0.
